barret_modmul_pipe: RTL and testbench
=====================================

BARRET_MODMUL_PIPE -- requirements
Module: barret_modmul_pipe

Interface
REQ-001 SHALL have parameter DAT_BITS, default 256, modulus/result width.
REQ-002 SHALL have parameter CTL_BITS, default 8, sideband tag width carried with each transaction.
REQ-003 SHALL have parameter P, DAT_BITS wide, default 100000000, modulus; P >= 3 and P < 2^DAT_BITS.
REQ-004 SHALL have parameter MULT_LAT, default 2 (range 1-4), register stages per internal multiply.
REQ-005 SHALL have port i_clk, input, 1, the single clock.
REQ-006 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port i_dat, input, 2*DAT_BITS, operand: x in reduce mode; a = [DAT_BITS-1:0], b = [2*DAT_BITS-1:DAT_BITS] in multiply mode.
REQ-008 SHALL have port i_mul, input, 1, mode: 0 = reduce x mod P, 1 = compute (a*b) mod P.
REQ-009 SHALL have port i_val, input, 1, input valid.
REQ-010 SHALL have port i_ctl, input, CTL_BITS, tag.
REQ-011 SHALL have port o_rdy, output, 1, input ready.
REQ-012 SHALL have port o_dat, output, DAT_BITS, result.
REQ-013 SHALL have port o_ctl, output, CTL_BITS, tag of result.
REQ-014 SHALL have port o_err, output, 1, range error flag qualified by o_val.
REQ-015 SHALL have port o_val, output, 1, output valid.
REQ-016 SHALL have port i_rdy, input, 1, downstream ready.

Function
REQ-017 SHALL accept a transaction on a cycle with i_val && o_rdy, and deliver one on a cycle with o_val && i_rdy.
REQ-018 SHALL have fixed latency L = 3*MULT_LAT + 2 cycles, accept to o_val, in both modes; results emerge in acceptance order.
REQ-019 SHALL drive o_rdy = !(o_val && !i_rdy); the whole pipeline (valids, data, tags) stalls on that condition and holds all stage contents unchanged.
REQ-020 SHALL sustain one transaction per cycle when i_rdy stays high; back-to-back and bubble patterns preserve order and tags.
REQ-021 SHALL, in multiply mode, form x = a*b (stage group 1, MULT_LAT); in reduce mode it SHALL delay x by MULT_LAT unchanged.
REQ-022 SHALL compute Barrett quotient q = ((x >> (k-1)) * MU) >> (k+1), with k = bit length of P and MU = floor(4^k / P) (stage group 2).
REQ-023 SHALL compute r = x - q*P (stage group 3), truncated to DAT_BITS+2 bits.
REQ-024 SHALL apply up to two conditional subtractions of P over the final 2 stages (one per stage), giving 0 <= o_dat < P.
REQ-025 SHALL set o_err = 1 and o_dat = 0 for reduce-mode inputs with x >= P*P; multiply mode SHALL set o_err = 1, o_dat = 0 when a >= P or b >= P; otherwise o_err = 0.
REQ-026 SHALL propagate i_ctl unchanged to o_ctl alongside its result.
REQ-027 SHALL hold o_dat, o_ctl and o_err stable while o_val && !i_rdy.

Reset
REQ-028 SHALL, on i_rst_n low, asynchronously clear all stage valids, o_val, o_err, o_dat and o_ctl to 0; o_rdy SHALL read 1 during and after reset.
REQ-029 SHALL discard in-flight transactions on reset mid-operation; the first output after release SHALL come from the first post-reset acceptance.
REQ-030 SHALL not need data-path registers cleared beyond the valid bits for correctness.

Structure
REQ-031 SHALL place the MU and k computation functions and the latency constant in shared package barret_pkg.
REQ-032 SHALL instantiate one sub-module pipe_mult (parametrised widths, MULT_LAT stages, enable input tied to !stall) three times.
REQ-033 SHALL target 120-400 lines of RTL, no external multiplier interfaces.

Verification (DAT_BITS=8, P=251, MU=261, k=8, MULT_LAT=2, L=8)
REQ-034 SHALL check reduce x=1000, ctl=0x5A -> after 8 cycles o_dat=247, o_ctl=0x5A, o_err=0.
REQ-035 SHALL check multiply a=250, b=250 -> o_dat=1, o_err=0; and a=0, b=200 -> o_dat=0.
REQ-036 SHALL check reduce x=63001 (P^2) -> o_err=1, o_dat=0; x=63000 -> o_dat=250, o_err=0.
REQ-037 SHALL check 20 back-to-back mixed-mode inputs with random i_rdy -> results in order, matching a reference model, with no loss or duplication, and o_rdy=0 exactly when o_val && !i_rdy.
REQ-038 SHALL check i_rst_n pulsed low with 5 transactions in flight -> o_val=0 immediately, and no stale output after release.

Source files
------------

// File: rtl/barret_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett modular multiplier.
package barret_pkg;

   localparam int unsigned BARRET_MAX_BITS = 1024;

   typedef enum logic {
      MODE_REDUCE = 1'b0,
      MODE_MUL    = 1'b1
   } mode_e;

   function automatic int unsigned bit_len(input logic [BARRET_MAX_BITS-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < BARRET_MAX_BITS; i++) begin
         if (v[i]) n = i + 1;
      end
      return n;
   endfunction

   // MU = floor(4^k / p); 2k must stay below BARRET_MAX_BITS.
   function automatic logic [BARRET_MAX_BITS-1:0] barrett_mu(input logic [BARRET_MAX_BITS-1:0] p);
      logic [BARRET_MAX_BITS-1:0] pow4k;
      pow4k = '0;
      pow4k[2*bit_len(p)] = 1'b1;
      return pow4k / p;
   endfunction

   function automatic int unsigned pipe_latency(input int unsigned mult_lat);
      return 3 * mult_lat + 2;
   endfunction

endpackage

// File: rtl/pipe_mult.sv
// Pipelined multiplier with a sideband lane delayed in lockstep; output is the
// product shifted right by SHIFT and truncated to O_BITS.
module pipe_mult #(
   parameter int unsigned A_BITS  = 8,
   parameter int unsigned B_BITS  = 8,
   parameter int unsigned O_BITS  = 16,
   parameter int unsigned SHIFT   = 0,
   parameter int unsigned SB_BITS = 1,
   parameter int unsigned LAT     = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_vld,
   input  logic [A_BITS-1:0]  i_a,
   input  logic [B_BITS-1:0]  i_b,
   input  logic [SB_BITS-1:0] i_sb,
   output logic               o_vld,
   output logic [O_BITS-1:0]  o_p,
   output logic [SB_BITS-1:0] o_sb
);

   localparam int unsigned LP_FULL = A_BITS + B_BITS;

   logic [LAT-1:0]     r_vld;
   logic [O_BITS-1:0]  r_p  [LAT];
   logic [SB_BITS-1:0] r_sb [LAT];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
      end else if (i_en) begin
         r_vld[0] <= i_vld;
         for (int unsigned i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   // Data lanes carry no reset; only the valid bits qualify them.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         r_p[0]  <= O_BITS'((LP_FULL'(i_a) * LP_FULL'(i_b)) >> SHIFT);
         r_sb[0] <= i_sb;
         for (int unsigned i = 1; i < LAT; i++) begin
            r_p[i]  <= r_p[i-1];
            r_sb[i] <= r_sb[i-1];
         end
      end
   end

   assign o_vld = r_vld[LAT-1];
   assign o_p   = r_p[LAT-1];
   assign o_sb  = r_sb[LAT-1];

endmodule

// File: rtl/barret_modmul_pipe.sv
// Fully pipelined Barrett reduction / modular multiply with valid-ready flow
// control; the whole pipe freezes while the output is held by downstream.
module barret_modmul_pipe
   import barret_pkg::*;
#(
   parameter int unsigned         DAT_BITS = 256,
   parameter int unsigned         CTL_BITS = 8,
   parameter logic [DAT_BITS-1:0] P        = DAT_BITS'(100000000),
   parameter int unsigned         MULT_LAT = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [2*DAT_BITS-1:0] i_dat,
   input  logic                  i_mul,
   input  logic                  i_val,
   input  logic [CTL_BITS-1:0]   i_ctl,
   output logic                  o_rdy,
   output logic [DAT_BITS-1:0]   o_dat,
   output logic [CTL_BITS-1:0]   o_ctl,
   output logic                  o_err,
   output logic                  o_val,
   input  logic                  i_rdy
);

   localparam int unsigned           LP_K   = bit_len(BARRET_MAX_BITS'(P));
   localparam logic [DAT_BITS+1:0]   LP_MU  = (DAT_BITS+2)'(barrett_mu(BARRET_MAX_BITS'(P)));
   localparam logic [2*DAT_BITS-1:0] LP_PP  = (2*DAT_BITS)'(P) * (2*DAT_BITS)'(P);
   localparam logic [DAT_BITS+1:0]   LP_P2  = (DAT_BITS+2)'(P);
   localparam int unsigned           LP_SB1 = 2 + CTL_BITS + 2*DAT_BITS;
   localparam int unsigned           LP_SB2 = 1 + CTL_BITS + DAT_BITS + 2;

   logic                  w_stall;
   logic                  w_en;
   mode_e                 w_mode;
   logic [DAT_BITS-1:0]   w_a;
   logic [DAT_BITS-1:0]   w_b;
   logic                  w_err_in;
   logic [LP_SB1-1:0]     w_sb1_in;

   logic                  w_v1;
   logic [2*DAT_BITS-1:0] w_p1;
   logic [LP_SB1-1:0]     w_sb1;
   logic [2*DAT_BITS-1:0] w_x1;
   logic [DAT_BITS:0]     w_xs;
   logic [LP_SB2-1:0]     w_sb2_in;

   logic                  w_v2;
   logic [DAT_BITS:0]     w_q2;
   logic [LP_SB2-1:0]     w_sb2;

   logic                  w_v3;
   logic [DAT_BITS+1:0]   w_qp3;
   logic [LP_SB2-1:0]     w_sb3;
   logic [DAT_BITS+1:0]   w_x3;
   logic [DAT_BITS+1:0]   w_r3;
   logic [DAT_BITS+1:0]   w_ra_sub;

   logic                  r_va;
   logic [DAT_BITS+1:0]   r_ra;
   logic                  r_erra;
   logic [CTL_BITS-1:0]   r_ctla;
   logic                  r_val;
   logic [DAT_BITS-1:0]   r_dat;
   logic [CTL_BITS-1:0]   r_ctl;
   logic                  r_err;

   assign w_stall = r_val && !i_rdy;
   assign w_en    = !w_stall;
   assign o_rdy   = !w_stall;

   assign w_mode   = mode_e'(i_mul);
   assign w_a      = i_dat[DAT_BITS-1:0];
   assign w_b      = i_dat[2*DAT_BITS-1:DAT_BITS];
   assign w_err_in = (w_mode == MODE_MUL) ? ((w_a >= P) || (w_b >= P)) : (i_dat >= LP_PP);
   assign w_sb1_in = {i_mul, w_err_in, i_ctl, i_dat};

   pipe_mult #(
      .A_BITS (DAT_BITS),
      .B_BITS (DAT_BITS),
      .O_BITS (2*DAT_BITS),
      .SHIFT  (0),
      .SB_BITS(LP_SB1),
      .LAT    (MULT_LAT)
   ) u_mul_ab (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (w_en),
      .i_vld  (i_val),
      .i_a    (w_a),
      .i_b    (w_b),
      .i_sb   (w_sb1_in),
      .o_vld  (w_v1),
      .o_p    (w_p1),
      .o_sb   (w_sb1)
   );

   // Reduce mode bypasses the product with the operand delayed through the sideband.
   assign w_x1     = w_sb1[LP_SB1-1] ? w_p1 : w_sb1[2*DAT_BITS-1:0];
   assign w_xs     = (DAT_BITS+1)'(w_x1 >> (LP_K - 1));
   assign w_sb2_in = {w_sb1[LP_SB1-2], w_sb1[2*DAT_BITS +: CTL_BITS], w_x1[DAT_BITS+1:0]};

   pipe_mult #(
      .A_BITS (DAT_BITS+1),
      .B_BITS (DAT_BITS+2),
      .O_BITS (DAT_BITS+1),
      .SHIFT  (LP_K + 1),
      .SB_BITS(LP_SB2),
      .LAT    (MULT_LAT)
   ) u_mul_mu (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (w_en),
      .i_vld  (w_v1),
      .i_a    (w_xs),
      .i_b    (LP_MU),
      .i_sb   (w_sb2_in),
      .o_vld  (w_v2),
      .o_p    (w_q2),
      .o_sb   (w_sb2)
   );

   pipe_mult #(
      .A_BITS (DAT_BITS+1),
      .B_BITS (DAT_BITS),
      .O_BITS (DAT_BITS+2),
      .SHIFT  (0),
      .SB_BITS(LP_SB2),
      .LAT    (MULT_LAT)
   ) u_mul_p (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (w_en),
      .i_vld  (w_v2),
      .i_a    (w_q2),
      .i_b    (P),
      .i_sb   (w_sb2),
      .o_vld  (w_v3),
      .o_p    (w_qp3),
      .o_sb   (w_sb3)
   );

   // The true remainder is below 3P, so DAT_BITS+2 bits of the difference suffice.
   assign w_x3     = w_sb3[DAT_BITS+1:0];
   assign w_r3     = w_x3 - w_qp3;
   assign w_ra_sub = (r_ra >= LP_P2) ? (r_ra - LP_P2) : r_ra;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_va  <= 1'b0;
         r_val <= 1'b0;
         r_dat <= '0;
         r_ctl <= '0;
         r_err <= 1'b0;
      end else if (w_en) begin
         r_va  <= w_v3;
         r_val <= r_va;
         r_dat <= r_erra ? '0 : DAT_BITS'(w_ra_sub);
         r_ctl <= r_ctla;
         r_err <= r_erra;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_en) begin
         r_ra   <= (w_r3 >= LP_P2) ? (w_r3 - LP_P2) : w_r3;
         r_erra <= w_sb3[LP_SB2-1];
         r_ctla <= w_sb3[DAT_BITS+2 +: CTL_BITS];
      end
   end

   assign o_val = r_val;
   assign o_dat = r_dat;
   assign o_ctl = r_ctl;
   assign o_err = r_err;

endmodule

// File: tb/tb_barret_modmul_pipe.sv
// Randomised and directed bench for barret_modmul_pipe at DAT_BITS=8, P=251,
// checked against a plain-arithmetic modular model and an in-order scoreboard.
module tb_barret_modmul_pipe;

   localparam int unsigned TB_P   = 251;
   localparam int unsigned TB_LAT = 8;

   logic        i_clk;
   logic        i_rst_n;
   logic [15:0] i_dat;
   logic        i_mul;
   logic        i_val;
   logic [7:0]  i_ctl;
   logic        o_rdy;
   logic [7:0]  o_dat;
   logic [7:0]  o_ctl;
   logic        o_err;
   logic        o_val;
   logic        i_rdy;

   barret_modmul_pipe #(
      .DAT_BITS(8),
      .CTL_BITS(8),
      .P       (8'd251),
      .MULT_LAT(2)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_dat  (i_dat),
      .i_mul  (i_mul),
      .i_val  (i_val),
      .i_ctl  (i_ctl),
      .o_rdy  (o_rdy),
      .o_dat  (o_dat),
      .o_ctl  (o_ctl),
      .o_err  (o_err),
      .o_val  (o_val),
      .i_rdy  (i_rdy)
   );

   typedef struct {
      logic [7:0]  dat;
      logic        err;
      logic [7:0]  ctl;
      int unsigned cyc;
      bit          lat;
   } exp_t;

   exp_t        q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   bit          rdy_rand = 0;
   bit          prev_stall = 0;
   logic [17:0] prev_out = '0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic mul, input logic [15:0] d, input logic [7:0] c);
      exp_t        e;
      int unsigned a, b, x;
      a = d[7:0];
      b = d[15:8];
      x = d;
      e.ctl = c;
      e.cyc = 0;
      e.lat = 0;
      if (mul) begin
         e.err = (a >= TB_P) || (b >= TB_P);
         e.dat = e.err ? 8'd0 : 8'((a * b) % TB_P);
      end else begin
         e.err = (x >= TB_P * TB_P);
         e.dat = e.err ? 8'd0 : 8'(x % TB_P);
      end
      return e;
   endfunction

   always @(negedge i_clk) begin
      exp_t e;
      if (!i_rst_n) begin
         prev_stall = 0;
      end else begin
         check("o_rdy", 32'(o_rdy), 32'(!(o_val && !i_rdy)));
         if (prev_stall) check("hold", 32'({o_val, o_err, o_ctl, o_dat}), 32'(prev_out));
         if (o_val && i_rdy) begin
            if (q.size() == 0) begin
               check("spurious_out", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("o_dat", 32'(o_dat), 32'(e.dat));
               check("o_err", 32'(o_err), 32'(e.err));
               check("o_ctl", 32'(o_ctl), 32'(e.ctl));
               if (e.lat) check("latency", cyc - e.cyc, TB_LAT);
            end
         end
         if (i_val && o_rdy) begin
            e     = model(i_mul, i_dat, i_ctl);
            e.cyc = cyc;
            e.lat = !rdy_rand;
            q.push_back(e);
         end
         prev_stall = o_val && !i_rdy;
         prev_out   = {o_val, o_err, o_ctl, o_dat};
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
      i_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   task automatic send(input logic mul, input logic [15:0] dat, input logic [7:0] ctl);
      bit acc;
      acc   = 0;
      i_val = 1'b1;
      i_mul = mul;
      i_dat = dat;
      i_ctl = ctl;
      for (int g = 0; g < 200; g++) begin
         @(negedge i_clk);
         acc = o_rdy;
         tick();
         if (acc) break;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      i_val = 1'b0;
   endtask

   task automatic drain();
      for (int g = 0; g < 500 && q.size() != 0; g++) tick();
      check("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_dat   = '0;
      i_mul   = 1'b0;
      i_val   = 1'b0;
      i_ctl   = '0;
      i_rdy   = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      check("rst_o_val", 32'(o_val), 32'd0);
      check("rst_o_rdy", 32'(o_rdy), 32'd1);
      check("rst_o_dat", 32'(o_dat), 32'd0);
      check("rst_o_ctl", 32'(o_ctl), 32'd0);
      check("rst_o_err", 32'(o_err), 32'd0);
      tick();

      // Directed vectors with downstream always ready: also checks latency.
      send(1'b0, 16'd1000, 8'h5A);
      drain();
      send(1'b1, {8'd250, 8'd250}, 8'h01);
      send(1'b1, {8'd200, 8'd0}, 8'h02);
      send(1'b0, 16'd63001, 8'h03);
      send(1'b0, 16'd63000, 8'h04);
      send(1'b1, {8'd3, 8'd251}, 8'h05);
      send(1'b1, {8'd251, 8'd5}, 8'h06);
      send(1'b0, 16'd0, 8'h07);
      send(1'b0, 16'd65535, 8'h08);
      send(1'b0, 16'd250, 8'h09);
      send(1'b1, {8'd1, 8'd250}, 8'h0A);
      drain();

      // Random mixed traffic with random backpressure; first 20 are back-to-back.
      rdy_rand = 1;
      for (int i = 0; i < 80; i++) begin
         logic mul;
         mul = 1'($urandom_range(0, 1));
         if (mul) send(1'b1, {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))}, 8'(i + 16));
         else     send(1'b0, 16'($urandom_range(0, 65535)), 8'(i + 16));
         if (i >= 20 && $urandom_range(0, 3) == 0) tick();
      end
      drain();
      rdy_rand = 0;
      tick();

      // Reset with five transactions in flight.
      for (int i = 0; i < 5; i++) send(1'b0, 16'(1000 + i), 8'(8'hE0 + i));
      #2;
      i_rst_n = 1'b0;
      #1;
      check("midrst_o_val", 32'(o_val), 32'd0);
      check("midrst_o_rdy", 32'(o_rdy), 32'd1);
      check("midrst_o_dat", 32'(o_dat), 32'd0);
      check("midrst_o_ctl", 32'(o_ctl), 32'd0);
      q.delete();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      send(1'b1, {8'd7, 8'd9}, 8'hC1);
      send(1'b0, 16'd502, 8'hC2);
      send(1'b0, 16'd777, 8'hC3);
      drain();
      repeat (15) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
